round_sequencer: RTL
====================

// Module: round_sequencer
// PURPOSE
//   Sequences the 8-entry challenge ROM (60-bit words). Steps the ROM address one round at a time and latches the word.
//   Drives LEDs and the servo preset, then judges the player: either a 4-char serial answer or a BCD sensor reading.
//   Sits between the ROM, the UART receiver, the sensor front end and the servo/LED drivers.
// PARAMETERS
//   N_ROUNDS        8         rounds per game (1..8); ROM addresses 0..N_ROUNDS-1
//   TIMEOUT_CYCLES  50000000  cycles allowed per round before a loss (1 s @ 50 MHz)
//   TERM_CHAR       7'h23     answer terminator ('#')
// PORTS
//   clock          in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   iniciar        in   1   start pulse (1 cycle); ignored unless IDLE/WIN/LOSE
//   mem_address    out  3   ROM address
//   mem_data       in   60  ROM word (combinational ROM, valid same cycle)
//   rx_char        in   7   received ASCII char
//   rx_valid       in   1   1-cycle strobe, rx_char valid
//   sensor_bcd     in   12  3-digit BCD reading
//   sensor_valid   in   1   1-cycle strobe, sensor_bcd valid
//   leds           out  4   round LEDs (word[57:54])
//   servo_pos      out  2   servo start position (word[53:52])
//   servo_load     out  1   1-cycle pulse: servo loads servo_pos
//   servo_en       out  1   servo controls enabled (opcode 01/10)
//   acerto         out  1   1-cycle pulse on correct round
//   score          out  4   rounds passed this game
//   ganhou / perdeu out 1   game-over flags, held until iniciar or reset
//   db_estado      out  3   current state encoding
// BEHAVIOUR
//   Word fields: op=[59:58] led=[57:54] pos=[53:52] inf=[51:40] sup=[39:28] exp=[27:0].
//   Reset: state=IDLE, mem_address=0, every output 0, answer buffer=0, char count=0, timer=0.
//   States (db_estado): IDLE=0 FETCH=1 PRESENT=2 WAIT=3 CHECK=4 NEXT=5 WIN=6 LOSE=7.
//   IDLE/WIN/LOSE --iniciar--> FETCH. Clears address, score, ganhou, perdeu.
//   FETCH (1 cycle): latch mem_data into the round register, then -> PRESENT.
//   PRESENT (1 cycle): drive leds/servo_pos, pulse servo_load, set servo_en=(op==01||op==10).
//     Clear buffer, count and timer, then -> WAIT.
//   WAIT, op!=11: on rx_valid, buffer <= {buffer[20:0],rx_char}, count saturates at 4.
//     rx_char==TERM_CHAR: the terminator is shifted in first, then -> CHECK.
//     First char ends in [27:21], terminator in [6:0]; "B$1#" = {B,$,1,#}.
//     sensor_valid is ignored.
//   WAIT, op==11: on sensor_valid, capture sensor_bcd and go -> CHECK. rx_valid is ignored.
//   Timer increments every WAIT cycle. Reaching TIMEOUT_CYCLES-1 -> LOSE. A valid strobe on that same cycle wins over the timeout.
//   CHECK (1 cycle):
//     op!=11: pass = (count==4) && (buffer==exp).
//     op==11: pass = inf <= reading <= sup, 12-bit unsigned compare (BCD order-preserving); bounds inclusive.
//     pass -> acerto pulse, score+1, -> NEXT. Fail -> LOSE.
//   NEXT (1 cycle): address==N_ROUNDS-1 -> WIN. Otherwise address+1 -> FETCH. Address never wraps mid-game.
//   WIN: ganhou=1. LOSE: perdeu=1. In both, leds=0 and servo_en=0.
//   reset at any time returns to the reset state immediately. iniciar during FETCH..NEXT is ignored.
//   Latency: iniciar -> servo_load = 3 cycles; terminator strobe -> acerto = 2 cycles.
// TESTING
//   1) ROM 0 (01,led 0010,pos 11,"B$1#"): start, send B,$,1,# -> servo_load pos=3, leds=0010, acerto, score=1, addr=1.
//   2) ROM 0: send B,$,2,# -> perdeu=1, state LOSE, score=0, leds=0; then iniciar -> addr=0, perdeu=0.
//   3) ROM 6 (sensor 070..080): readings 12'h070 and 12'h080 pass; 12'h069 and 12'h081 -> LOSE; rx ignored.
//   4) No input for TIMEOUT_CYCLES (set 100) -> LOSE at cycle 100; strobe on cycle 99 -> CHECK instead.
//   5) Send only "$1#" (3 chars) on ROM 0 -> LOSE. Send "XB$1#" -> buffer holds B$1# -> pass.
//   6) Full correct game N_ROUNDS=8 -> score=8, ganhou=1; assert reset mid-WAIT -> all outputs 0 at once.

Source files
------------

// File: rtl/round_sequencer.sv
// Round sequencer for the challenge game: fetches one 60-bit ROM word per round,
// presents it on the LEDs/servo, then judges a serial answer or a BCD sensor reading.
module round_sequencer #(
  parameter int unsigned N_ROUNDS       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [6:0]  TERM_CHAR      = 7'h23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  output logic [2:0]  mem_address,
  input  logic [59:0] mem_data,
  input  logic [6:0]  rx_char,
  input  logic        rx_valid,
  input  logic [11:0] sensor_bcd,
  input  logic        sensor_valid,
  output logic [3:0]  leds,
  output logic [1:0]  servo_pos,
  output logic        servo_load,
  output logic        servo_en,
  output logic        acerto,
  output logic [3:0]  score,
  output logic        ganhou,
  output logic        perdeu,
  output logic [2:0]  db_estado
);

  localparam int unsigned TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LAST_ADDR  = 3'(N_ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    PRESENT = 3'd2,
    WAIT    = 3'd3,
    CHECK   = 3'd4,
    NEXT    = 3'd5,
    WIN     = 3'd6,
    LOSE    = 3'd7
  } state_t;

  state_t          state, state_next;
  logic [59:0]     word;
  logic [27:0]     buffer;
  logic [2:0]      count;
  logic [TW-1:0]   timer;
  logic [11:0]     reading;
  logic            sensor_mode, done_strobe, timed_out, pass;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, WIN, LOSE: if (iniciar) state_next = FETCH;
      FETCH:           state_next = PRESENT;
      PRESENT:         state_next = WAIT;
      // The answer strobe takes priority over an expiring timer.
      WAIT: begin
        if (done_strobe)    state_next = CHECK;
        else if (timed_out) state_next = LOSE;
      end
      CHECK:           state_next = pass ? NEXT : LOSE;
      NEXT:            state_next = (mem_address == LAST_ADDR) ? WIN : FETCH;
      default:         state_next = IDLE;
    endcase
  end

  always_comb begin
    sensor_mode = (word[59:58] == 2'b11);
    done_strobe = sensor_mode ? sensor_valid : (rx_valid && (rx_char == TERM_CHAR));
    timed_out   = (timer >= TIMER_LAST);
    if (sensor_mode) pass = (reading >= word[51:40]) && (reading <= word[39:28]);
    else             pass = (count == 3'd4) && (buffer == word[27:0]);
    db_estado   = state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_address <= '0;
      word        <= '0;
      buffer      <= '0;
      count       <= '0;
      timer       <= '0;
      reading     <= '0;
      leds        <= '0;
      servo_pos   <= '0;
      servo_load  <= 1'b0;
      servo_en    <= 1'b0;
      acerto      <= 1'b0;
      score       <= '0;
      ganhou      <= 1'b0;
      perdeu      <= 1'b0;
    end else begin
      servo_load <= 1'b0;
      acerto     <= 1'b0;
      case (state)
        IDLE, WIN, LOSE: begin
          if (iniciar) begin
            mem_address <= '0;
            score       <= '0;
            ganhou      <= 1'b0;
            perdeu      <= 1'b0;
          end
        end
        FETCH: word <= mem_data;
        PRESENT: begin
          leds       <= word[57:54];
          servo_pos  <= word[53:52];
          servo_load <= 1'b1;
          servo_en   <= (word[59:58] == 2'b01) || (word[59:58] == 2'b10);
          buffer     <= '0;
          count      <= '0;
          timer      <= '0;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (!sensor_mode && rx_valid) begin
            buffer <= {buffer[20:0], rx_char};
            if (count != 3'd4) count <= count + 3'd1;
          end
          if (sensor_mode && sensor_valid) reading <= sensor_bcd;
        end
        CHECK: begin
          if (pass) begin
            acerto <= 1'b1;
            score  <= score + 4'd1;
          end
        end
        NEXT: if (mem_address != LAST_ADDR) mem_address <= mem_address + 3'd1;
        default: ;
      endcase
      if (state_next == WIN && state != WIN) begin
        ganhou   <= 1'b1;
        leds     <= '0;
        servo_en <= 1'b0;
      end
      if (state_next == LOSE && state != LOSE) begin
        perdeu   <= 1'b1;
        leds     <= '0;
        servo_en <= 1'b0;
      end
    end
  end

endmodule
